// File: rtl/anim_sequencer_pkg.sv
// Shared types and the default animation table for the sprite animation sequencer.
// Entries are sized for the largest supported configuration; instances may use less.
package anim_sequencer_pkg;

  localparam int TBL_N       = 8;
  localparam int TBL_FRAMES  = 8;
  localparam int TBL_HOLD_W  = 4;
  localparam int TBL_COORD_W = 11;
  localparam int WIDTH_W     = 6;

  typedef enum logic {
    LOOP    = 1'b0,
    ONESHOT = 1'b1
  } anim_mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [TBL_COORD_W-1:0]                 base_row;
    logic [TBL_COORD_W-1:0]                 base_col;
    logic [TBL_COORD_W-1:0]                 col_stride;
    logic [3:0]                             n_frames;
    logic [TBL_FRAMES-1:0][TBL_HOLD_W-1:0]  hold;
    logic [WIDTH_W-1:0]                     width;
    anim_mode_t                             mode;
  } anim_entry_t;

  // hold nibbles are listed frame 7 .. frame 0, left to right
  localparam anim_entry_t ANIM_TABLE [TBL_N] = '{
    '{11'd16,   11'd8,    11'd32,  4'd2,
      32'h33333333, 6'd32, LOOP},
    '{11'd64,   11'd0,    11'd46,  4'd4,
      32'h22222222, 6'd46, LOOP},
    '{11'd128,  11'd10,   11'd20,  4'd3,
      32'h11111111, 6'd20, ONESHOT},
    '{11'd200,  11'd5,    11'd100, 4'd8,
      32'h00000000, 6'd63, LOOP},
    '{11'd400,  11'd2000, 11'd30,  4'd3,
      32'h00000321, 6'd30, ONESHOT},
    '{11'd300,  11'd0,    11'd0,   4'd1,
      32'h11111111, 6'd16, LOOP},
    '{11'd320,  11'd0,    11'd0,   4'd1,
      32'h11111111, 6'd16, LOOP},
    '{11'd340,  11'd0,    11'd0,   4'd1,
      32'h11111111, 6'd16, LOOP}
  };

endpackage

// File: rtl/anim_sequencer_table.sv
// Combinational lookup: selection and frame to sheet coordinates,
// hold count, sprite width and playback mode.
module anim_table
  import anim_sequencer_pkg::*;
#(
  parameter int N_ANIM     = 8,
  parameter int MAX_FRAMES = 8,
  parameter int HOLD_W     = 4,
  parameter int COORD_W    = 11,
  parameter int SEL_W      = 4,
  parameter int FRAME_W    = 3
) (
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [FRAME_W-1:0] i_frame,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic [HOLD_W-1:0]  o_hold,
  output logic [FRAME_W:0]   o_n_frames,
  output logic [WIDTH_W-1:0] o_width,
  output anim_mode_t         o_mode
);

  localparam int IDX_W = $clog2(TBL_N);
  localparam int FI_W  = $clog2(TBL_FRAMES);

  logic [IDX_W-1:0]       w_idx;
  logic [FI_W-1:0]        w_fi;
  anim_entry_t            w_entry;
  logic [TBL_COORD_W-1:0] w_col;

  // out-of-range selections fall back to entry 0
  assign w_idx = (i_sel < SEL_W'(N_ANIM)) ? IDX_W'(i_sel) : '0;
  assign w_fi  = FI_W'(i_frame);

  assign w_entry = ANIM_TABLE[w_idx];
  assign w_col   = w_entry.base_col
                 + TBL_COORD_W'(i_frame) * w_entry.col_stride;

  assign o_row      = COORD_W'(w_entry.base_row);
  assign o_col      = COORD_W'(w_col);
  assign o_hold     = HOLD_W'(w_entry.hold[w_fi]);
  assign o_n_frames = (FRAME_W+1)'(w_entry.n_frames);
  assign o_width    = w_entry.width;
  assign o_mode     = w_entry.mode;

endmodule

// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: steps frames of the selected table entry
// on frame-rate ticks, looping or stopping after one pass.
module anim_sequencer
  import anim_sequencer_pkg::*;
#(
  parameter  int N_ANIM     = 8,
  parameter  int MAX_FRAMES = 8,
  parameter  int HOLD_W     = 4,
  parameter  int COORD_W    = 11,
  // one spare bit so out-of-range requests are representable
  localparam int SEL_W      = $clog2(N_ANIM) + 1,
  localparam int FRAME_W    = $clog2(MAX_FRAMES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               anim_tick,
  input  logic [SEL_W-1:0]   anim_sel,
  input  logic               restart,
  output logic [COORD_W-1:0] anim_row,
  output logic [COORD_W-1:0] anim_col,
  output logic [5:0]         max_width,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               anim_done,
  output logic               busy
);

  localparam int NF_W = FRAME_W + 1;

  seq_state_t         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_cnt_nxt;
  logic               r_done, w_done_nxt;

  logic [COORD_W-1:0] w_row, w_col;
  logic [HOLD_W-1:0]  w_hold, w_hold_eff;
  logic [NF_W-1:0]    w_nfr;
  logic [5:0]         w_width;
  anim_mode_t         w_mode;
  logic               w_last_cnt, w_last_frame;

  anim_table #(
    .N_ANIM     (N_ANIM),
    .MAX_FRAMES (MAX_FRAMES),
    .HOLD_W     (HOLD_W),
    .COORD_W    (COORD_W),
    .SEL_W      (SEL_W),
    .FRAME_W    (FRAME_W)
  ) u_table (
    .i_sel      (r_sel),
    .i_frame    (r_frame),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_hold     (w_hold),
    .o_n_frames (w_nfr),
    .o_width    (w_width),
    .o_mode     (w_mode)
  );

  assign w_hold_eff   = (w_hold == '0) ? HOLD_W'(1) : w_hold;
  assign w_last_cnt   = (r_hold_cnt == w_hold_eff - HOLD_W'(1));
  assign w_last_frame = ({1'b0, r_frame} == w_nfr - NF_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_hold_cnt;
    w_done_nxt  = 1'b0;
    // reselect/restart outranks any tick in the same cycle
    if (anim_sel != r_sel || restart) begin
      w_sel_nxt   = anim_sel;
      w_frame_nxt = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = RUN;
    end else if (r_state == RUN && anim_tick) begin
      if (!w_last_cnt) begin
        w_cnt_nxt = r_hold_cnt + HOLD_W'(1);
      end else begin
        w_cnt_nxt = '0;
        if (!w_last_frame) begin
          w_frame_nxt = r_frame + FRAME_W'(1);
        end else if (w_mode == LOOP) begin
          w_frame_nxt = '0;
        end else begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_sel      <= '0;
      r_frame    <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_frame    <= w_frame_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // outputs come only from registered state through the table
  assign anim_row  = w_row;
  assign anim_col  = w_col;
  assign max_width = w_width;
  assign frame_idx = r_frame;
  assign anim_done = r_done;
  assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed self-checking bench for anim_sequencer.
module tb_anim_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        anim_tick = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  anim_sel = 4'd0;
  logic [10:0] anim_row, anim_col;
  logic [5:0]  max_width;
  logic [2:0]  frame_idx;
  logic        anim_done, busy;

  int checks = 0;
  int errors = 0;

  anim_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .anim_tick (anim_tick),
    .anim_sel  (anim_sel),
    .restart   (restart),
    .anim_row  (anim_row),
    .anim_col  (anim_col),
    .max_width (max_width),
    .frame_idx (frame_idx),
    .anim_done (anim_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         t;
    logic [3:0] s;
    bit         r;
    int         f;
    int         row;
    int         col;
    int         w;
    int         d;
    int         b;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit t, input logic [3:0] s, input bit r);
    @(negedge clk);
    anim_tick = t;
    anim_sel  = s;
    restart   = r;
    @(posedge clk);
    #1;
    anim_tick = 1'b0;
    restart   = 1'b0;
  endtask

  task automatic outs(input string tag, input int f, input int row,
                      input int col, input int w, input int d, input int b);
    chk({tag, ".frame"}, int'(frame_idx), f);
    chk({tag, ".row"},   int'(anim_row), row);
    chk({tag, ".col"},   int'(anim_col), col);
    chk({tag, ".width"}, int'(max_width), w);
    chk({tag, ".done"},  int'(anim_done), d);
    chk({tag, ".busy"},  int'(busy), b);
  endtask

  initial begin
    int ndone;

    v[0]  = '{1, 1, 0, 0, 64,   0, 46, 0, 1};
    v[1]  = '{1, 1, 0, 0, 64,   0, 46, 0, 1};
    v[2]  = '{1, 1, 0, 1, 64,  46, 46, 0, 1};
    v[3]  = '{0, 1, 0, 1, 64,  46, 46, 0, 1};
    v[4]  = '{1, 1, 0, 1, 64,  46, 46, 0, 1};
    v[5]  = '{1, 1, 0, 2, 64,  92, 46, 0, 1};
    v[6]  = '{1, 1, 0, 2, 64,  92, 46, 0, 1};
    v[7]  = '{1, 1, 0, 3, 64, 138, 46, 0, 1};
    v[8]  = '{1, 1, 0, 3, 64, 138, 46, 0, 1};
    v[9]  = '{1, 1, 0, 0, 64,   0, 46, 0, 1};
    v[10] = '{1, 1, 0, 0, 64,   0, 46, 0, 1};
    v[11] = '{1, 1, 0, 1, 64,  46, 46, 0, 1};
    v[12] = '{1, 1, 0, 1, 64,  46, 46, 0, 1};
    v[13] = '{1, 1, 0, 2, 64,  92, 46, 0, 1};
    v[14] = '{1, 1, 0, 2, 64,  92, 46, 0, 1};

    #1;
    outs("reset", 0, 16, 8, 32, 0, 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(v[i].t, v[i].s, v[i].r);
      outs($sformatf("vec%0d", i), v[i].f, v[i].row, v[i].col,
           v[i].w, v[i].d, v[i].b);
    end

    cyc(1, 2, 0);
    outs("switch", 0, 128, 10, 20, 0, 1);
    chk("switch.holdcnt", int'(dut.r_hold_cnt), 0);
    chk("switch.sel", int'(dut.r_sel), 2);

    ndone = 0;
    cyc(1, 2, 0); ndone += int'(anim_done);
    outs("os1", 1, 128, 30, 20, 0, 1);
    cyc(1, 2, 0); ndone += int'(anim_done);
    outs("os2", 2, 128, 50, 20, 0, 1);
    cyc(1, 2, 0); ndone += int'(anim_done);
    outs("os3", 2, 128, 50, 20, 1, 0);
    cyc(1, 2, 0); ndone += int'(anim_done);
    outs("os4", 2, 128, 50, 20, 0, 0);
    cyc(1, 2, 0); ndone += int'(anim_done);
    outs("os5", 2, 128, 50, 20, 0, 0);
    chk("os.donecount", ndone, 1);

    cyc(0, 2, 1);
    outs("restart", 0, 128, 10, 20, 0, 1);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2, 0);
      ndone += int'(anim_done);
    end
    chk("restart.donecount", ndone, 1);
    outs("restart.end", 2, 128, 50, 20, 1, 0);

    cyc(0, 2, 1);
    cyc(1, 2, 0);
    cyc(1, 2, 0);
    outs("sup.pre", 2, 128, 50, 20, 0, 1);
    cyc(1, 1, 0);
    outs("sup.sel", 0, 64, 0, 46, 0, 1);

    for (int i = 0; i < 6; i++) cyc(1, 1, 0);
    outs("rst.pre", 3, 64, 138, 46, 0, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    anim_sel = 4'd0;
    #1;
    outs("rst.async", 0, 16, 8, 32, 0, 1);
    chk("rst.sel", int'(dut.r_sel), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 0, 0);
    outs("rst.t1", 0, 16, 8, 32, 0, 1);
    cyc(1, 0, 0);
    outs("rst.t2", 0, 16, 8, 32, 0, 1);
    cyc(1, 0, 0);
    outs("rst.t3", 1, 16, 40, 32, 0, 1);

    cyc(0, 9, 0);
    outs("sel9", 0, 16, 8, 32, 0, 1);
    chk("sel9.latched", int'(dut.r_sel), 9);
    cyc(1, 9, 0);
    cyc(1, 9, 0);
    outs("sel9.t2", 0, 16, 8, 32, 0, 1);
    cyc(1, 9, 0);
    outs("sel9.t3", 1, 16, 40, 32, 0, 1);

    cyc(0, 3, 0);
    outs("hold0.sel", 0, 200, 5, 63, 0, 1);
    cyc(1, 3, 0);
    outs("hold0.t1", 1, 200, 105, 63, 0, 1);

    cyc(0, 4, 0);
    outs("trunc.sel", 0, 400, 2000, 30, 0, 1);
    cyc(1, 4, 0);
    outs("trunc.t1", 1, 400, 2030, 30, 0, 1);
    cyc(1, 4, 0);
    outs("trunc.t2", 1, 400, 2030, 30, 0, 1);
    cyc(1, 4, 0);
    outs("trunc.t3", 2, 400, 12, 30, 0, 1);
    cyc(1, 4, 0);
    cyc(1, 4, 0);
    outs("trunc.t5", 2, 400, 12, 30, 0, 1);
    cyc(1, 4, 0);
    outs("trunc.t6", 2, 400, 12, 30, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
